wash_cycle_timer: RTL and testbench

- Program timer and sequencer that sits beside automatic_washing_machine.
- Watches the machine's phase outputs (soap_wash, water_wash, motor_on, drain_value_on, door_lock, done).
- Generates the cycle_timeout and spin_timeout inputs the machine consumes, from tick-driven down-counters scaled by a selected wash program.
- Reports busy, remaining time and a fill-valve watchdog fault to the front panel.

---
 rtl/wash_cycle_timer_if.sv | 23 ++
 rtl/wash_cycle_timer.sv | 179 +++++++++++++++++
 tb/tb_wash_cycle_timer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/wash_cycle_timer_if.sv
// Machine-side signal bundle between automatic_washing_machine and wash_cycle_timer.
// The machine drives the phase indicators; the timer answers with the two timeouts.
interface wash_cycle_timer_if;
  logic door_lock;
  logic soap_wash;
  logic water_wash;
  logic motor_on;
  logic drain_value_on;
  logic fill_value_on;
  logic done;
  logic cycle_timeout;
  logic spin_timeout;

  modport master (
    output door_lock, soap_wash, water_wash, motor_on, drain_value_on, fill_value_on, done,
    input  cycle_timeout, spin_timeout
  );

  modport slave (
    input  door_lock, soap_wash, water_wash, motor_on, drain_value_on, fill_value_on, done,
    output cycle_timeout, spin_timeout
  );
endinterface

// File: rtl/wash_cycle_timer.sv
// Phase sequencer and tick-driven duration timer for the washing machine.
// Optional fill-valve watchdog is built only when FILL_WATCHDOG_EN is defined.
module wash_cycle_timer #(
  parameter int CNT_W       = 16,
  parameter int WASH_TICKS  = 100,
  parameter int RINSE_TICKS = 60,
  parameter int SPIN_TICKS  = 80,
  parameter int FILL_LIMIT  = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [1:0]           program_sel,
  wash_cycle_timer_if.slave    mach,
  output logic                 busy,
  output logic [CNT_W-1:0]     remaining,
  output logic                 fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    WASH   = 3'd2,
    RINSE  = 3'd3,
    SPIN   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t     state;
  logic [1:0] prog;
  logic       hold;
  logic       spin_cond;

  logic [CNT_W-1:0] wash_load;
  logic [CNT_W-1:0] rinse_load;
  logic [CNT_W-1:0] spin_load;

  // Quick halves, heavy doubles with saturation; a zero result still times one tick.
  function automatic logic [CNT_W-1:0] scale(input logic [63:0] n, input logic [1:0] sel);
    logic [63:0] v;
    logic [63:0] lim;
    lim = (64'd1 << CNT_W) - 64'd1;
    case (sel)
      2'b01:   v = n >> 1;
      2'b10:   v = n << 1;
      default: v = n;
    endcase
    if (v > lim) v = lim;
    if (v == 64'd0) v = 64'd1;
    return v[CNT_W-1:0];
  endfunction

  assign wash_load  = scale(64'(WASH_TICKS), prog);
  assign rinse_load = scale(64'(RINSE_TICKS), prog);
  assign spin_load  = scale(64'(SPIN_TICKS), prog);
  assign spin_cond  = mach.drain_value_on & mach.motor_on;

`ifdef FILL_WATCHDOG_EN
  localparam int FW = $clog2(FILL_LIMIT + 1) + 1;

  logic [FW-1:0] fill_cnt;
  logic          trip;

  assign trip = mach.fill_value_on && busy && tick &&
                ((fill_cnt + 1'b1) >= FW'(FILL_LIMIT));
  assign hold = fault | trip;

  // trip feeds hold directly so the timeouts drop on the same edge fault rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      if (trip) fault <= 1'b1;
      if (!mach.fill_value_on)
        fill_cnt <= '0;
      else if (busy && tick && (fill_cnt < FW'(FILL_LIMIT)))
        fill_cnt <= fill_cnt + 1'b1;
    end
  end
`else
  assign fault = 1'b0;
  assign hold  = 1'b0;
`endif

  // remaining doubles as the phase counter; it is cleared on every timed-phase exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      prog               <= 2'b00;
      busy               <= 1'b0;
      remaining          <= '0;
      mach.cycle_timeout <= 1'b0;
      mach.spin_timeout  <= 1'b0;
    end else if (hold) begin
      mach.cycle_timeout <= 1'b0;
      mach.spin_timeout  <= 1'b0;
    end else if ((state inside {WAIT, WASH, RINSE, SPIN}) && !mach.door_lock) begin
      state              <= IDLE;
      busy               <= 1'b0;
      remaining          <= '0;
      mach.cycle_timeout <= 1'b0;
      mach.spin_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mach.door_lock) begin
            state <= WAIT;
            prog  <= program_sel;
            busy  <= 1'b1;
          end
        end

        WAIT: begin
          if (spin_cond) begin
            state     <= SPIN;
            remaining <= spin_load;
          end else if (mach.water_wash) begin
            state     <= RINSE;
            remaining <= rinse_load;
          end else if (mach.soap_wash) begin
            state     <= WASH;
            remaining <= wash_load;
          end else if (mach.done) begin
            state <= FINISH;
            busy  <= 1'b0;
          end
        end

        WASH: begin
          if (!mach.soap_wash) begin
            state              <= WAIT;
            remaining          <= '0;
            mach.cycle_timeout <= 1'b0;
          end else if (remaining == '0) begin
            mach.cycle_timeout <= 1'b1;
          end else if (tick) begin
            remaining <= remaining - 1'b1;
          end
        end

        RINSE: begin
          if (!mach.water_wash) begin
            state              <= WAIT;
            remaining          <= '0;
            mach.cycle_timeout <= 1'b0;
          end else if (remaining == '0) begin
            mach.cycle_timeout <= 1'b1;
          end else if (tick) begin
            remaining <= remaining - 1'b1;
          end
        end

        SPIN: begin
          if (!spin_cond) begin
            state             <= WAIT;
            remaining         <= '0;
            mach.spin_timeout <= 1'b0;
          end else if (remaining == '0) begin
            mach.spin_timeout <= 1'b1;
          end else if (tick) begin
            remaining <= remaining - 1'b1;
          end
        end

        FINISH: begin
          if (!mach.done && !mach.door_lock) state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          remaining <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Directed bench for wash_cycle_timer with small durations (CNT_W=4, WASH=4, RINSE=12, SPIN=1).
// Watchdog expectations switch on FILL_WATCHDOG_EN so the bench matches either build.
module tb_wash_cycle_timer;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             tick;
  logic [1:0]       program_sel;
  logic             busy;
  logic [CNT_W-1:0] remaining;
  logic             fault;

  int checks;
  int passed;

  wash_cycle_timer_if bus ();

  wash_cycle_timer #(
    .CNT_W      (CNT_W),
    .WASH_TICKS (4),
    .RINSE_TICKS(12),
    .SPIN_TICKS (1),
    .FILL_LIMIT (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .program_sel(program_sel),
    .mach       (bus),
    .busy       (busy),
    .remaining  (remaining),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the machine phase lines, then advance one clock and settle 1 time unit past the edge.
  task automatic applyStimulus(input logic dl, input logic soap, input logic water,
                               input logic spin, input logic fill, input logic dn);
    bus.door_lock      = dl;
    bus.soap_wash      = soap;
    bus.water_wash     = water;
    bus.motor_on       = spin;
    bus.drain_value_on = spin;
    bus.fill_value_on  = fill;
    bus.done           = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  initial begin
    checks      = 0;
    passed      = 0;
    reset       = 1'b1;
    tick        = 1'b1;
    program_sel = 2'b00;
    bus.door_lock      = 1'b0;
    bus.soap_wash      = 1'b0;
    bus.water_wash     = 1'b0;
    bus.motor_on       = 1'b0;
    bus.drain_value_on = 1'b0;
    bus.fill_value_on  = 1'b0;
    bus.done           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_remaining", 32'(remaining), 0);
    checkOutput("rst_cto", 32'(bus.cycle_timeout), 0);
    checkOutput("rst_sto", 32'(bus.spin_timeout), 0);
    checkOutput("rst_fault", 32'(fault), 0);
    reset = 1'b0;

    $display("[TB] normal wash");
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("wait_busy", 32'(busy), 1);
    checkOutput("wait_remaining", 32'(remaining), 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("wash_entry_rem", 32'(remaining), 4);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("wash_rem3", 32'(remaining), 3);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("wash_rem2", 32'(remaining), 2);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("wash_rem1", 32'(remaining), 1);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("wash_rem0", 32'(remaining), 0);
    checkOutput("wash_cto_early", 32'(bus.cycle_timeout), 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("wash_cto_rise", 32'(bus.cycle_timeout), 1);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("wash_cto_hold", 32'(bus.cycle_timeout), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("wash_exit_cto", 32'(bus.cycle_timeout), 0);
    checkOutput("wash_exit_busy", 32'(busy), 1);

    $display("[TB] tick gating");
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("reentry_rem", 32'(remaining), 4);
    tick = 1'b0;
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("no_tick_rem", 32'(remaining), 4);
    tick = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("tick_rem", 32'(remaining), 3);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("tick_exit_rem", 32'(remaining), 0);

    $display("[TB] quick spin and async reset");
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("idle_busy", 32'(busy), 0);
    program_sel = 2'b01;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("quick_wait_busy", 32'(busy), 1);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("spin_entry_rem", 32'(remaining), 1);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("spin_rem0", 32'(remaining), 0);
    checkOutput("spin_sto_early", 32'(bus.spin_timeout), 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("spin_sto_rise", 32'(bus.spin_timeout), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_sto", 32'(bus.spin_timeout), 0);
    checkOutput("async_busy", 32'(busy), 0);
    checkOutput("async_fault", 32'(fault), 0);
    #2;
    reset = 1'b0;
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("post_rst_rem", 32'(remaining), 0);
    checkOutput("post_rst_busy", 32'(busy), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] heavy rinse saturation");
    program_sel = 2'b10;
    applyStimulus(1, 0, 0, 0, 0, 0);
    program_sel = 2'b01;
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("heavy_rinse_sat", 32'(remaining), 15);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("heavy_rinse_dec", 32'(remaining), 14);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rinse_exit_rem", 32'(remaining), 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("rinse_reload", 32'(remaining), 15);
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkOutput("rinse_dec_again", 32'(remaining), 14);
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("heavy_wash_load", 32'(remaining), 8);
    applyStimulus(1, 0, 0, 0, 0, 0);

    $display("[TB] abort mid wash");
    applyStimulus(0, 0, 0, 0, 0, 0);
    program_sel = 2'b00;
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("abort_pre_rem", 32'(remaining), 2);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_rem", 32'(remaining), 0);
    checkOutput("abort_cto", 32'(bus.cycle_timeout), 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("abort_stays_idle", 32'(remaining), 0);

    $display("[TB] done path");
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("done_wait_busy", 32'(busy), 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("finish_busy", 32'(busy), 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("finish_holds_rem", 32'(remaining), 0);
    checkOutput("finish_holds_busy", 32'(busy), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("finish_to_idle", 32'(busy), 1);

    $display("[TB] fill watchdog");
    applyStimulus(1, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkOutput("fill_two_ticks", 32'(fault), 0);
    applyStimulus(1, 0, 0, 0, 1, 0);
`ifdef FILL_WATCHDOG_EN
    checkOutput("fill_trip", 32'(fault), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("fault_sticky", 32'(fault), 1);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("fault_hold_rem", 32'(remaining), 0);
    repeat (6) applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("fault_no_cto", 32'(bus.cycle_timeout), 0);
    checkOutput("fault_still", 32'(fault), 1);
`else
    checkOutput("fill_no_fault", 32'(fault), 0);
    applyStimulus(1, 1, 0, 0, 1, 0);
    checkOutput("fill_wash_rem", 32'(remaining), 4);
    checkOutput("fill_fault_tied", 32'(fault), 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
